// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter.
//   DATA_W        operand and result width
//   FLAG_*        bit positions inside the 4-bit flag vector {N, Z, V, C}
//   CNT_W         width of the settle counter (covers SETTLE_CYCLES up to 15)
//   state_t       arbiter FSM states
package addsub_arbiter_pkg;

    localparam int DATA_W = 64;
    localparam int FLAG_W = 4;
    localparam int CNT_W  = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_arbiter_addsub_unit.sv
// Purely combinational 64-bit adder/subtractor with condition flags.
//   a, b    operands
//   sub     0: a + b, 1: a + ~b + 1
//   result  sum or difference, modulo 2^DATA_W
//   flags   {negative, zero, overflow, carryout}
module addsub_unit
    import addsub_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] low_sum;
    logic [1:0]        msb_sum;
    logic              carry_into_msb;
    logic              carry_out;

    // The add is split at the MSB so the carry into bit 63 is visible
    // for the signed-overflow flag.
    always_comb begin
        b_eff          = sub ? ~b : b;
        low_sum        = {1'b0, a[DATA_W-2:0]} + {1'b0, b_eff[DATA_W-2:0]}
                       + {{(DATA_W-1){1'b0}}, sub};
        carry_into_msb = low_sum[DATA_W-1];
        msb_sum        = {1'b0, a[DATA_W-1]} + {1'b0, b_eff[DATA_W-1]}
                       + {1'b0, carry_into_msb};
        carry_out      = msb_sum[1];
        result         = {msb_sum[0], low_sum[DATA_W-2:0]};

        flags          = '0;
        flags[FLAG_N]  = result[DATA_W-1];
        flags[FLAG_Z]  = (result == '0);
        flags[FLAG_V]  = carry_into_msb ^ carry_out;
        flags[FLAG_C]  = carry_out;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of a shared add/subtract unit.
// A granted operation is latched, held on the unit for SETTLE_CYCLES
// cycles, then its result is offered on the response channel until the
// consumer takes it. Only one operation is in flight at a time.
//   clk, reset_n                       clock, asynchronous active-low reset
//   reqN_valid/ready                   request handshake for requester N
//   reqN_a, reqN_b, reqN_sub           operands and operation (1 = A-B)
//   resp_valid/ready                   response handshake
//   resp_id, resp_result, resp_flags   owner, result, {N, Z, V, C}
//   busy                               high whenever the FSM is not IDLE
// SETTLE_CYCLES legal range: 1..15.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic [FLAG_W-1:0] resp_flags,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ptr_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic              sub_reg;
    logic              id_reg;
    logic              resp_id_reg;
    logic [DATA_W-1:0] resp_result_reg;
    logic [FLAG_W-1:0] resp_flags_reg;

    logic              grant_id;
    logic [DATA_W-1:0] grant_a, grant_b;
    logic              grant_sub;
    logic [1:0]        req_valid, req_ready;
    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] unit_result;
    logic [FLAG_W-1:0] unit_flags;

    assign req_valid = {req1_valid, req0_valid};

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ptr_reg;
        end else begin
            grant_id = req1_valid;
        end
        grant_a   = grant_id ? req1_a   : req0_a;
        grant_b   = grant_id ? req1_b   : req0_b;
        grant_sub = grant_id ? req1_sub : req0_sub;
    end

    // Ready is gated by reset_n so it drops together with the registered
    // outputs the moment reset is asserted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = reset_n && (state_reg == IDLE)
                                 && req_valid[gi] && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |req_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. The RESP handshake goes straight to IDLE, so a new
    // request can only be accepted in the following cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch and response registers. Operands are captured only on
    // the accept edge, so requester inputs are free to change afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg         <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            sub_reg         <= 1'b0;
            id_reg          <= 1'b0;
            resp_id_reg     <= 1'b0;
            resp_result_reg <= '0;
            resp_flags_reg  <= '0;
        end else begin
            if (accept) begin
                a_reg   <= grant_a;
                b_reg   <= grant_b;
                sub_reg <= grant_sub;
                id_reg  <= grant_id;
                ptr_reg <= ~grant_id;
            end
            if (capture) begin
                resp_id_reg     <= id_reg;
                resp_result_reg <= unit_result;
                resp_flags_reg  <= unit_flags;
            end
        end
    end

    addsub_unit u_addsub_unit (
        .a      (a_reg),
        .b      (b_reg),
        .sub    (sub_reg),
        .result (unit_result),
        .flags  (unit_flags)
    );

    assign resp_valid  = (state_reg == RESP);
    assign busy        = (state_reg != IDLE);
    assign resp_id     = resp_id_reg;
    assign resp_result = resp_result_reg;
    assign resp_flags  = resp_flags_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

    localparam int SETTLE = 4;

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic [3:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [63:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [63:0] resp_result;
    logic [3:0]  resp_flags;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    addsub_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_sub    (req0_sub),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_sub    (req1_sub),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flags derived from unsigned/signed comparisons.
    function automatic exp_t model(input logic id, input logic [63:0] a,
                                   input logic [63:0] b, input logic sub);
        exp_t        e;
        logic [63:0] r;
        logic        c, v;
        if (!sub) begin
            {c, r} = {1'b0, a} + {1'b0, b};
            v = (a[63] == b[63]) && (r[63] != a[63]);
        end else begin
            r = a - b;
            c = (a >= b);
            v = (a[63] != b[63]) && (r[63] != a[63]);
        end
        e.id    = id;
        e.res   = r;
        e.flags = {r[63], (r == 64'd0), v, c};
        return e;
    endfunction

    // Scoreboard: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (reset_n && resp_valid && resp_ready) begin
            resp_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got id=%0d res=%h flags=%b want no response",
                         resp_id, resp_result, resp_flags);
            end else begin
                mon_e = sb.pop_front();
                if ({resp_id, resp_result, resp_flags} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_resp got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                             resp_id, resp_result, resp_flags, mon_e.id, mon_e.res, mon_e.flags);
                end
                $display("resp id=%0d res=%h flags=%b", resp_id, resp_result, resp_flags);
            end
        end
    end

    task automatic drive_req(input int port, input logic v, input logic [63:0] a,
                             input logic [63:0] b, input logic sub);
        if (port == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
        end
    endtask

    task automatic send(input int port, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, output int acc);
        logic rdy;
        acc = -1;
        drive_req(port, 1'b1, a, b, sub);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            rdy = (port == 0) ? req0_ready : req1_ready;
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout port=%0d got ready=0 want ready=1", port);
        end else begin
            sb.push_back(model(port[0], a, b, sub));
            $display("req port=%0d a=%h b=%h sub=%0d accepted cyc=%0d", port, a, b, sub, acc);
        end
        @(posedge clk); #1;
        drive_req(port, 1'b0, a, b, sub);
    endtask

    task automatic wait_resp(input string name);
        bit seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_resp_timeout got resp_valid=0 want 1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain got busy=%0b pending=%0d want busy=0 pending=0",
                     name, busy, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resp_ready = 1'b1;
        drive_req(0, 1'b1, 64'd5, 64'd7, 1'b0);
        drive_req(1, 1'b1, 64'd3, 64'd10, 1'b1);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_flags, busy} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b id=%0b res=%h fl=%b busy=%0b want all 0",
                     resp_valid, resp_id, resp_result, resp_flags, busy);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        $display("reset released");
    endtask

    // Both requesters hold valid from the first cycle after reset.
    task automatic test_contention();
        int got;
        bit both;
        for (int g = 0; g < 4; g++) begin
            got = -1;
            both = 0;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got  = req1_ready ? 1 : 0;
                    both = req0_ready && req1_ready;
                    break;
                end
            end
            checks++;
            if (got != (g % 2) || both) begin
                errors++;
                $display("FAIL contention_grant%0d got id=%0d both=%0b want id=%0d",
                         g, got, both, g % 2);
            end
            if (got == 0) sb.push_back(model(1'b0, req0_a, req0_b, req0_sub));
            if (got == 1) sb.push_back(model(1'b1, req1_a, req1_b, req1_sub));
            $display("contention grant %0d -> id=%0d", g, got);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("contention");
    endtask

    task automatic test_add_neg();
        int acc;
        bit seen = 0;
        send(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, acc);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || (cyc - acc) != SETTLE + 1) begin
            errors++;
            $display("FAIL add_neg_latency got %0d want %0d", cyc - acc, SETTLE + 1);
        end
        checks++;
        if ({resp_id, resp_result, resp_flags} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000}) begin
            errors++;
            $display("FAIL add_neg_value got id=%0d res=%h fl=%b want id=0 res=ffffffffffffffff fl=1000",
                     resp_id, resp_result, resp_flags);
        end
        wait_idle("add_neg");
    endtask

    task automatic test_sub_ovf();
        int acc;
        send(1, 64'h8000_0000_0000_0000, 64'h1, 1'b1, acc);
        wait_resp("sub_ovf");
        checks++;
        if ({resp_id, resp_result, resp_flags} !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011}) begin
            errors++;
            $display("FAIL sub_ovf_value got id=%0d res=%h fl=%b want id=1 res=7fffffffffffffff fl=0011",
                     resp_id, resp_result, resp_flags);
        end
        wait_idle("sub_ovf");
    endtask

    task automatic test_add_carry();
        int acc;
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, acc);
        wait_resp("add_carry");
        checks++;
        if ({resp_result, resp_flags} !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b1001}) begin
            errors++;
            $display("FAIL add_carry_value got res=%h fl=%b want res=fffffffffffffffe fl=1001",
                     resp_result, resp_flags);
        end
        wait_idle("add_carry");
    endtask

    task automatic test_backpressure();
        int acc;
        resp_ready = 1'b0;
        send(0, 64'h1, 64'h1, 1'b1, acc);
        wait_resp("bp");
        // A competing request while the response is stalled must not be taken.
        drive_req(1, 1'b1, 64'd9, 64'd1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, resp_result, resp_flags, req0_ready, req1_ready, busy}
                    !== {1'b1, 64'h0, 4'b0101, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0b res=%h fl=%b rdy=%b%b busy=%0b want v=1 res=0 fl=0101 rdy=00 busy=1",
                         n, resp_valid, resp_result, resp_flags, req1_ready, req0_ready, busy);
            end
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake_ready got %0b want 0", req1_ready);
        end
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept got %0b want 1", req1_ready);
        end else begin
            sb.push_back(model(1'b1, 64'd9, 64'd1, 1'b0));
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle("bp");
    endtask

    task automatic test_reset_mid();
        int acc;
        int rc;
        send(0, 64'd2, 64'd3, 1'b0, acc);   // pointer now favours requester 1
        @(posedge clk); #1;                   // second SETTLE cycle
        req0_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_flags, busy, req0_ready, req1_ready} !== 73'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%0b id=%0b res=%h fl=%b busy=%0b rdy=%b%b want all 0",
                     resp_valid, resp_id, resp_result, resp_flags, busy, req1_ready, req0_ready);
        end
        sb.delete();
        rc = resp_count;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (resp_count != rc || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_discard got resps=%0d busy=%0b want resps=%0d busy=0",
                     resp_count, busy, rc);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b1, 64'd11, 64'd4, 1'b1);
        drive_req(1, 1'b1, 64'd12, 64'd4, 1'b0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_ptr got rdy=%b%b want 01", req1_ready, req0_ready);
        end else begin
            sb.push_back(model(1'b0, 64'd11, 64'd4, 1'b1));
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("rst_mid");
    endtask

    task automatic test_random();
        int          acc;
        logic [63:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            b = (i == 3) ? a : {$urandom, $urandom};
            send(int'($urandom_range(1, 0)), a, b, 1'($urandom_range(1, 0)), acc);
            wait_idle("random");
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_add_neg();
        test_sub_ovf();
        test_add_carry();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
